axis_packetizer: RTL

AXIS_PACKETIZER -- requirements
Module: axis_packetizer

---
 rtl/axis_packetizer_if.sv | 40 ++++
 rtl/axis_packetizer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/axis_packetizer_if.sv
// axis_packetizer_if
//   Bundles the command handshake, the payload stream into the packetizer
//   and the packet stream out to the router.
//   slave  : packetizer side (consumes cmd_* and s_*, produces m_*)
//   master : driver side (produces cmd_* and s_*, consumes m_*)
interface axis_packetizer_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ID_WIDTH      = 4,
   parameter int MAX_ROUTERS_X = 4,
   parameter int MAX_ROUTERS_Y = 4
);
   localparam int XW = $clog2(MAX_ROUTERS_X);
   localparam int YW = $clog2(MAX_ROUTERS_Y);

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [XW-1:0]         cmd_x;
   logic [YW-1:0]         cmd_y;
   logic [7:0]            cmd_len;

   logic [DATA_WIDTH-1:0] s_tdata;
   logic                  s_tvalid;
   logic                  s_tready;

   logic [DATA_WIDTH-1:0] m_tdata;
   logic [ID_WIDTH-1:0]   m_tid;
   logic                  m_tlast;
   logic                  m_tvalid;
   logic                  m_tready;

   modport slave (
      input  cmd_valid, cmd_x, cmd_y, cmd_len, s_tdata, s_tvalid, m_tready,
      output cmd_ready, s_tready, m_tdata, m_tid, m_tlast, m_tvalid
   );

   modport master (
      output cmd_valid, cmd_x, cmd_y, cmd_len, s_tdata, s_tvalid, m_tready,
      input  cmd_ready, s_tready, m_tdata, m_tid, m_tlast, m_tvalid
   );
endinterface

// File: rtl/axis_packetizer.sv
// axis_packetizer
//   Turns a command (destination x/y, payload length) plus a payload stream
//   into a router packet: one header beat followed by len+1 payload beats,
//   TLAST on the final payload beat. All m_* outputs come from a single
//   registered slot; full throughput when the router keeps m_tready high.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus (slave)  : cmd_valid/cmd_ready/cmd_x/cmd_y/cmd_len command handshake,
//                  s_tdata/s_tvalid/s_tready payload in,
//                  m_tdata/m_tid/m_tlast/m_tvalid/m_tready packet out
//
// Build option
//   PACKETIZER_SRC_COORD_EN : header also carries the local router
//                             coordinates (ROUTER_Y, ROUTER_X) above the
//                             destination; needs DATA_WIDTH >= 4*XW.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a command; payload input blocked
// PAY   | header issued, forwarding payload; cnt_q = beats left minus one
module axis_packetizer #(
   parameter int DATA_WIDTH    = 32,
   parameter int ID_WIDTH      = 4,
   parameter int MAX_ROUTERS_X = 4,
   parameter int MAX_ROUTERS_Y = 4,
   parameter int ROUTER_X      = 0,
   parameter int ROUTER_Y      = 0,
   parameter int HEADER_ID     = 0,
   parameter int DATA_ID       = 1
) (
   input logic               clk,
   input logic               rst_n,
   axis_packetizer_if.slave  bus
);
   localparam int XW = $clog2(MAX_ROUTERS_X);
   localparam int YW = $clog2(MAX_ROUTERS_Y);

   if (XW != YW) begin : g_bad_coord_width
      $error("axis_packetizer: MAX_ROUTERS_X and MAX_ROUTERS_Y must give equal coordinate widths");
   end
`ifdef PACKETIZER_SRC_COORD_EN
   if (DATA_WIDTH < 4*XW) begin : g_bad_data_width
      $error("axis_packetizer: DATA_WIDTH too small for source-coordinate header");
   end
`else
   if (DATA_WIDTH < 2*XW) begin : g_bad_data_width
      $error("axis_packetizer: DATA_WIDTH too small for header");
   end
`endif

   typedef enum logic {
      IDLE = 1'b0,
      PAY  = 1'b1
   } state_e;

   state_e                state_q;
   logic [7:0]            cnt_q;
   logic [DATA_WIDTH-1:0] tdata_q;
   logic [ID_WIDTH-1:0]   tid_q;
   logic                  tlast_q;
   logic                  tvalid_q;
   // Keeps both ready outputs low until the first edge after reset release.
   logic                  run_q;

   logic                  slot_free;
   logic                  cmd_fire;
   logic                  s_fire;
   logic [DATA_WIDTH-1:0] hdr_d;

   assign slot_free     = !tvalid_q || bus.m_tready;
   assign bus.cmd_ready = run_q && (state_q == IDLE) && slot_free;
   assign bus.s_tready  = run_q && (state_q == PAY) && slot_free;
   assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;
   assign s_fire        = bus.s_tvalid && bus.s_tready;

   assign bus.m_tdata   = tdata_q;
   assign bus.m_tid     = tid_q;
   assign bus.m_tlast   = tlast_q;
   assign bus.m_tvalid  = tvalid_q;

   always_comb begin
      hdr_d                = '0;
      hdr_d[YW-1:0]        = bus.cmd_y;
      hdr_d[XW+YW-1:YW]    = bus.cmd_x;
`ifdef PACKETIZER_SRC_COORD_EN
      hdr_d[3*XW-1:2*XW]   = XW'(ROUTER_Y);
      hdr_d[4*XW-1:3*XW]   = XW'(ROUTER_X);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         tdata_q  <= '0;
         tid_q    <= '0;
         tlast_q  <= 1'b0;
         tvalid_q <= 1'b0;
         run_q    <= 1'b0;
      end else begin
         run_q <= 1'b1;
         case (state_q)
            IDLE: begin
               if (cmd_fire) begin
                  tdata_q  <= hdr_d;
                  tid_q    <= ID_WIDTH'(HEADER_ID);
                  tlast_q  <= 1'b0;
                  tvalid_q <= 1'b1;
                  cnt_q    <= bus.cmd_len;
                  state_q  <= PAY;
               end else if (bus.m_tready) begin
                  tvalid_q <= 1'b0;
               end
            end
            PAY: begin
               if (s_fire) begin
                  tdata_q  <= bus.s_tdata;
                  tid_q    <= ID_WIDTH'(DATA_ID);
                  tlast_q  <= (cnt_q == 8'd0);
                  tvalid_q <= 1'b1;
                  // The counter stops at zero on the last beat rather than wrapping.
                  if (cnt_q == 8'd0) begin
                     state_q <= IDLE;
                  end else begin
                     cnt_q <= cnt_q - 8'd1;
                  end
               end else if (bus.m_tready) begin
                  tvalid_q <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
